pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the XM23 pipeline fetch stage. It holds the architectural fetch PC and selects the next PC from these sources: sequential next, branch-fail recovery address (LBPC), or exception vector. A redirect that arrives while the pipeline is stalled is latched and applied once the stall clears. Every redirect is followed by a timed pipeline-flush window, and the block also supports a halt/resume state.

Parameters:
PC_W, 16, PC and address width in bits
STALL_W, 8, number of per-stage stall request bits
RESET_VEC, 0, value loaded into true_pc on reset (PC_W bits)
FLUSH_CYCLES, 2, flush-window length after a redirect (1..15)
ALIGN_LSB, 1, when 1, bit 0 of every loaded PC is forced to 0 (word-aligned fetch)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
pc_next  in  PC_W  sequential next PC from the fetch adder
lbpc  in  PC_W  last-branch PC used for misprediction recovery
branch_fail  in  1  branch mispredicted; redirect to lbpc
exc_req  in  1  exception/interrupt request; redirect to exc_vec
exc_vec  in  PC_W  exception handler address
halt_req  in  1  enter HALT
resume  in  1  leave HALT
stall_in  in  STALL_W  any bit set means the pipeline is stalled
true_pc  out  PC_W  current fetch PC
pc_valid  out  1  true_pc is fetchable this cycle
flush  out  1  squash younger pipeline stages
epc  out  PC_W  true_pc value captured when an exception is taken
state  out  2  current FSM state (RUN/FLUSH/HALT encoding from package)

Behaviour:
- Reset (asynchronous, rst_n=0): true_pc=RESET_VEC (aligned); state=RUN; pc_valid=1; flush=0; epc=0; pending redirect cleared; flush counter=0.
- Reset asserted mid-flush or mid-halt aborts that operation immediately. No pending redirect survives reset.
- Effective redirect in a cycle:
  - exc_req, else branch_fail, else the pending redirect if one is held.
  - exc_req always beats branch_fail.
  - A live request beats the pending one, except that a pending exception beats a live branch_fail.
- Stall (|stall_in=1), in RUN or FLUSH:
  - true_pc holds.
  - A live redirect is written into the pending register (target plus cause). A later exception overwrites a pending branch_fail; a later branch_fail never overwrites a pending exception.
  - The flush counter freezes.
- RUN, no stall:
  - If a redirect is effective: true_pc<=aligned target; if the cause is exception, epc<=current true_pc; pending clears; counter<=FLUSH_CYCLES; state<=FLUSH.
  - Else if halt_req: state<=HALT; true_pc holds.
  - Else: true_pc<=aligned pc_next.
- FLUSH, no stall:
  - flush=1 and pc_valid=0 for the whole state; true_pc holds the target.
  - The counter decrements each unstalled cycle; at 1→0, state<=RUN.
  - The state lasts exactly FLUSH_CYCLES unstalled cycles.
  - A new effective redirect in FLUSH reloads the target and counter; exception priority applies; epc updates only on exception.
- HALT:
  - pc_valid=0, flush=0; true_pc holds; stall_in and branch_fail are ignored.
  - resume → RUN in the next cycle.
  - exc_req → exception redirect into FLUSH, and takes priority over resume.
  - A pending redirect held on entry is kept and applied on the first unstalled RUN cycle.
- halt_req and a redirect in the same cycle: the redirect wins, and halt_req is dropped.
- Outputs are registered where noted: pc_valid=(state==RUN); flush=(state==FLUSH).
- No arithmetic is performed; PC values wrap naturally at 2^PC_W because the block only loads them.

Decomposition:
- Package pc_seq_pkg holds:
  - pc_state_t enum (RUN=0, FLUSH=1, HALT=2)
  - redirect_cause_t enum (NONE, BRANCH, EXC)
  - a pending-redirect struct {valid, cause, target}
  - the alignment helper function
- Sub-module pc_flush_timer holds the loadable down-counter with freeze input, done pulse, and width $clog2(FLUSH_CYCLES+1).

Test Plan:
- Reset release, stall_in=0, pc_next=true_pc+2 each cycle → true_pc 0000,0002,0004; pc_valid=1; flush=0.
- In RUN at true_pc=0010, branch_fail=1 with lbpc=0041 → next true_pc=0040; flush=1 and pc_valid=0 for 2 cycles; RUN at 0040; epc unchanged.
- stall_in=8'h04 for 3 cycles; branch_fail pulses with lbpc=0100 in stall cycle 1, and exc_req pulses with exc_vec=0200 in stall cycle 2 → true_pc holds; on stall release true_pc=0200, epc=pre-stall PC, flush window 2 cycles.
- During FLUSH with 1 cycle left, exc_req with exc_vec=0300 → target 0300; counter reloads; flush lasts 2 more cycles; epc=previous redirect target.
- halt_req at PC 0050 → HALT, pc_valid=0; branch_fail ignored; resume → RUN with true_pc=0050. Repeat with exc_req and resume together → FLUSH to exc_vec.
- Drive rst_n low mid-FLUSH with a pending redirect held → true_pc=RESET_VEC immediately; flush=0; after release, no stale redirect is applied.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the XM23 fetch PC sequencer.
// Redirect targets are carried at PC_MAX_W and narrowed at the point of use.
package pc_seq_pkg;

    localparam int PC_MAX_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        EXC    = 2'd2
    } redirect_cause_t;

    typedef struct packed {
        logic                  valid;
        redirect_cause_t       cause;
        logic [PC_MAX_W-1:0]   target;
    } pend_redirect_t;

    function automatic logic [PC_MAX_W-1:0] align_pc(
        input logic [PC_MAX_W-1:0] pc,
        input logic                en
    );
        logic [PC_MAX_W-1:0] r;
        r = pc;
        if (en) r[0] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/pc_flush_timer.sv
// Loadable down-counter timing the post-redirect flush window.
// done pulses on the unfrozen 1->0 step; load always wins.
module pc_flush_timer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic freeze,
    output logic done
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(FLUSH_CYCLES);
        end else if (!freeze && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign done = !load && !freeze && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: sequential/branch-recovery/exception
// PC selection, stall-deferred redirects, flush window and halt/resume.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W         = 16,
    parameter int              STALL_W      = 8,
    parameter logic [PC_W-1:0] RESET_VEC    = '0,
    parameter int              FLUSH_CYCLES = 2,
    parameter bit              ALIGN_LSB    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_next,
    input  logic [PC_W-1:0]    lbpc,
    input  logic               branch_fail,
    input  logic               exc_req,
    input  logic [PC_W-1:0]    exc_vec,
    input  logic               halt_req,
    input  logic               resume,
    input  logic [STALL_W-1:0] stall_in,
    output logic [PC_W-1:0]    true_pc,
    output logic               pc_valid,
    output logic               flush,
    output logic [PC_W-1:0]    epc,
    output logic [1:0]         state
);

    localparam logic [PC_W-1:0] RESET_PC =
        PC_W'(align_pc(PC_MAX_W'(RESET_VEC), ALIGN_LSB));

    pc_state_t         state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    pend_redirect_t    pend_q, pend_d;

    logic                  stalled;
    logic                  redir_valid;
    redirect_cause_t       redir_cause;
    logic [PC_MAX_W-1:0]   redir_tgt;
    logic                  tmr_load, tmr_freeze, tmr_done;

    assign stalled = |stall_in;

    // A held exception outranks a live branch_fail; otherwise live wins.
    always_comb begin
        redir_valid = 1'b1;
        redir_cause = EXC;
        redir_tgt   = PC_MAX_W'(exc_vec);
        if (exc_req) begin
            redir_cause = EXC;
        end else if (pend_q.valid && pend_q.cause == EXC) begin
            redir_tgt   = pend_q.target;
        end else if (branch_fail) begin
            redir_cause = BRANCH;
            redir_tgt   = PC_MAX_W'(lbpc);
        end else if (pend_q.valid) begin
            redir_cause = pend_q.cause;
            redir_tgt   = pend_q.target;
        end else begin
            redir_valid = 1'b0;
            redir_cause = NONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_d     = pend_q;
        tmr_load   = 1'b0;
        tmr_freeze = 1'b1;
        case (state_q)
            RUN, FLUSH: begin
                if (stalled) begin
                    if (exc_req) begin
                        pend_d = '{1'b1, EXC, PC_MAX_W'(exc_vec)};
                    end else if (branch_fail &&
                                 !(pend_q.valid && pend_q.cause == EXC)) begin
                        pend_d = '{1'b1, BRANCH, PC_MAX_W'(lbpc)};
                    end
                end else if (redir_valid) begin
                    pc_d     = PC_W'(align_pc(redir_tgt, ALIGN_LSB));
                    if (redir_cause == EXC) epc_d = pc_q;
                    pend_d   = '0;
                    tmr_load = 1'b1;
                    state_d  = FLUSH;
                end else if (state_q == RUN) begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        pc_d = PC_W'(align_pc(PC_MAX_W'(pc_next), ALIGN_LSB));
                    end
                end else begin
                    tmr_freeze = 1'b0;
                    if (tmr_done) state_d = RUN;
                end
            end
            HALT: begin
                if (exc_req) begin
                    pc_d     = PC_W'(align_pc(PC_MAX_W'(exc_vec), ALIGN_LSB));
                    epc_d    = pc_q;
                    pend_d   = '0;
                    tmr_load = 1'b1;
                    state_d  = FLUSH;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    pc_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .freeze(tmr_freeze),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
        end
    end

    assign true_pc  = pc_q;
    assign epc      = epc_q;
    assign state    = state_q;
    assign pc_valid = (state_q == RUN);
    assign flush    = (state_q == FLUSH);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table, hand-written halt/reset sequences and a randomized
// run against a cycle-level behavioural model of the PC sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_next, lbpc, exc_vec, true_pc, epc;
    logic        branch_fail, exc_req, halt_req, resume;
    logic [7:0]  stall_in;
    logic        pc_valid, flush;
    logic [1:0]  state;

    logic        use_adder;
    logic [15:0] pcn_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign pc_next = use_adder ? true_pc + 16'd2 : pcn_r;

    pc_sequencer #(
        .PC_W(16), .STALL_W(8), .RESET_VEC(16'h0000),
        .FLUSH_CYCLES(2), .ALIGN_LSB(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .lbpc(lbpc),
        .branch_fail(branch_fail), .exc_req(exc_req), .exc_vec(exc_vec),
        .halt_req(halt_req), .resume(resume), .stall_in(stall_in),
        .true_pc(true_pc), .pc_valid(pc_valid), .flush(flush),
        .epc(epc), .state(state)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        branch_fail = 0; exc_req = 0; halt_req = 0; resume = 0;
        stall_in = 0; lbpc = 0; exc_vec = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        bf;
        logic [15:0] lb;
        logic        ex;
        logic [15:0] ev;
        logic [7:0]  st;
        logic [15:0] e_pc;
        logic [1:0]  e_vf;
        logic [15:0] e_epc;
    } vec_t;

    function automatic vec_t row(logic bf, logic [15:0] lb, logic ex,
                                 logic [15:0] ev, logic [7:0] st,
                                 logic [15:0] e_pc, logic [1:0] e_vf,
                                 logic [15:0] e_epc);
        vec_t v;
        v.bf = bf; v.lb = lb; v.ex = ex; v.ev = ev; v.st = st;
        v.e_pc = e_pc; v.e_vf = e_vf; v.e_epc = e_epc;
        return v;
    endfunction

    // Behavioural model: mode 0=run 1=flush 2=halt
    int          m_mode, m_left;
    logic [15:0] m_pc, m_epc;
    bit          p_valid, p_exc;
    logic [15:0] p_tgt;

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_pc = 16'h0000; m_epc = 0;
        p_valid = 0; p_exc = 0; p_tgt = 0;
    endtask

    task automatic m_take(input bit is_exc, input logic [15:0] tgt);
        if (is_exc) m_epc = m_pc;
        m_pc = tgt & 16'hFFFE;
        p_valid = 0;
        m_mode = 1;
        m_left = 2;
    endtask

    task automatic m_step();
        if (m_mode == 2) begin
            if (exc_req) m_take(1, exc_vec);
            else if (resume) m_mode = 0;
        end else if (stall_in != 0) begin
            if (exc_req) begin
                p_valid = 1; p_exc = 1; p_tgt = exc_vec;
            end else if (branch_fail && !(p_valid && p_exc)) begin
                p_valid = 1; p_exc = 0; p_tgt = lbpc;
            end
        end else if (exc_req) m_take(1, exc_vec);
        else if (p_valid && p_exc) m_take(1, p_tgt);
        else if (branch_fail) m_take(0, lbpc);
        else if (p_valid) m_take(0, p_tgt);
        else if (m_mode == 0) begin
            if (halt_req) m_mode = 2;
            else m_pc = pc_next & 16'hFFFE;
        end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    vec_t vq[$];

    initial begin
        idle();
        use_adder = 1; pcn_r = 0;
        rst_n = 0;
        tick(); tick();
        chk("reset_pc", true_pc, 16'h0000);
        chk("reset_flags", {state, pc_valid, flush}, {2'd0, 1'b1, 1'b0});
        chk("reset_epc", epc, 16'h0000);
        rst_n = 1;

        for (int i = 1; i <= 8; i++)
            vq.push_back(row(0, 0, 0, 0, 0, 16'(2 * i), 2'b10, 0));
        vq.push_back(row(1, 16'h0041, 0, 0, 0, 16'h0040, 2'b01, 0));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0040, 2'b01, 0));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0040, 2'b10, 0));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0042, 2'b10, 0));
        vq.push_back(row(1, 16'h0100, 0, 0, 8'h04, 16'h0042, 2'b10, 0));
        vq.push_back(row(0, 0, 1, 16'h0200, 8'h04, 16'h0042, 2'b10, 0));
        vq.push_back(row(0, 0, 0, 0, 8'h04, 16'h0042, 2'b10, 0));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0200, 2'b01, 16'h0042));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0200, 2'b01, 16'h0042));
        vq.push_back(row(0, 0, 1, 16'h0300, 0, 16'h0300, 2'b01, 16'h0200));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0300, 2'b01, 16'h0200));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0300, 2'b10, 16'h0200));
        vq.push_back(row(0, 0, 0, 0, 0, 16'h0302, 2'b10, 16'h0200));

        foreach (vq[i]) begin
            idle();
            branch_fail = vq[i].bf; lbpc = vq[i].lb;
            exc_req = vq[i].ex; exc_vec = vq[i].ev; stall_in = vq[i].st;
            tick();
            chk($sformatf("vec%0d_pc", i), true_pc, vq[i].e_pc);
            chk($sformatf("vec%0d_vf", i), {pc_valid, flush}, vq[i].e_vf);
            chk($sformatf("vec%0d_epc", i), epc, vq[i].e_epc);
        end

        // Halt / resume around PC 0050
        idle(); branch_fail = 1; lbpc = 16'h0050; tick();
        idle(); tick(); tick();
        halt_req = 1; tick();
        chk("halt_enter_pc", true_pc, 16'h0050);
        chk("halt_enter_flags", {state, pc_valid, flush}, {2'd2, 1'b0, 1'b0});
        idle(); branch_fail = 1; lbpc = 16'h0999; stall_in = 8'hFF; tick();
        chk("halt_ignore_pc", true_pc, 16'h0050);
        chk("halt_ignore_state", state, 2'd2);
        idle(); resume = 1; tick();
        chk("resume_pc", true_pc, 16'h0050);
        chk("resume_flags", {state, pc_valid, flush}, {2'd0, 1'b1, 1'b0});
        idle(); halt_req = 1; tick();
        chk("halt2_state", state, 2'd2);
        idle(); exc_req = 1; resume = 1; exc_vec = 16'h0400; tick();
        chk("halt_exc_pc", true_pc, 16'h0400);
        chk("halt_exc_state", state, 2'd1);
        chk("halt_exc_epc", epc, 16'h0050);

        // Reset mid-flush with a pending branch held
        idle(); stall_in = 8'h01; branch_fail = 1; lbpc = 16'h0700; tick();
        chk("pend_hold_pc", true_pc, 16'h0400);
        #2 rst_n = 0;
        #1;
        chk("async_rst_pc", true_pc, 16'h0000);
        chk("async_rst_flags", {state, pc_valid, flush}, {2'd0, 1'b1, 1'b0});
        chk("async_rst_epc", epc, 16'h0000);
        idle();
        tick();
        rst_n = 1;
        tick();
        chk("no_stale_pc", true_pc, 16'h0002);
        chk("no_stale_flush", flush, 1'b0);

        // Randomized run against the model
        rst_n = 0; idle(); use_adder = 0;
        tick();
        m_reset();
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            stall_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) | 8'h01 : 8'h00;
            branch_fail = ($urandom_range(0, 9) == 0);
            exc_req     = ($urandom_range(0, 19) == 0);
            halt_req    = ($urandom_range(0, 14) == 0);
            resume      = ($urandom_range(0, 4) == 0);
            lbpc        = 16'($urandom);
            exc_vec     = 16'($urandom);
            pcn_r       = 16'($urandom);
            #0;
            m_step();
            tick();
            chk("rnd_pc", true_pc, m_pc);
            chk("rnd_epc", epc, m_epc);
            chk("rnd_flags", {state, pc_valid, flush},
                {2'(m_mode), m_mode == 0, m_mode == 1});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
